// File: rtl/forward_scoreboard_if.sv
// Handshake bundle between the ID stage and the forwarding scoreboard.
// The master side drives the ID instruction and per-stage result buses; the slave side returns the lookups.
`timescale 1ns/1ps
interface forward_scoreboard_if #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 3,
    parameter int NUM_SRC = 2
);
    logic                    id_valid;
    logic [6:0]              id_opcode;
    logic [2:0]              id_funct3;
    logic [4:0]              id_rd;
    logic [NUM_SRC*5-1:0]    id_rs;
    logic                    hold;
    logic                    flush;
    logic [DEPTH*XLEN-1:0]   stage_main_data;
    logic [DEPTH*XLEN-1:0]   stage_sub_data;
    logic [DEPTH*XLEN-1:0]   stage_csr_data;
    logic [NUM_SRC-1:0]      fwd_hit;
    logic [NUM_SRC*XLEN-1:0] fwd_data;
    logic                    load_use_stall;

    modport master (
        output id_valid, id_opcode, id_funct3, id_rd, id_rs, hold, flush,
        output stage_main_data, stage_sub_data, stage_csr_data,
        input  fwd_hit, fwd_data, load_use_stall
    );

    modport slave (
        input  id_valid, id_opcode, id_funct3, id_rd, id_rs, hold, flush,
        input  stage_main_data, stage_sub_data, stage_csr_data,
        output fwd_hit, fwd_data, load_use_stall
    );
endinterface

// File: rtl/forward_scoreboard.sv
// Operand forwarding and load-use hazard unit: tracks in-flight writes from EX onward and picks,
// per ID source operand, the youngest producer's data from the bus matching its class.
`timescale 1ns/1ps
module forward_scoreboard #(
    parameter int XLEN             = 32,
    parameter int DEPTH            = 3,
    parameter int NUM_SRC          = 2,
    parameter int LOAD_READY_STAGE = 1,
    parameter int CSR_READY_STAGE  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    forward_scoreboard_if.slave   bus
);

    typedef enum logic [2:0] {
        CLS_NONE = 3'd0,
        CLS_MAIN = 3'd1,
        CLS_SUB  = 3'd2,
        CLS_LOAD = 3'd3,
        CLS_CSR  = 3'd4
    } cls_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        cls_e       cls;
    } entry_t;

    entry_t ent_q [DEPTH];
    entry_t ent_d [DEPTH];

    logic [NUM_SRC-1:0]      lookup_hit;
    logic [NUM_SRC*XLEN-1:0] lookup_data;
    logic                    stall_raw;
    logic                    stall;
    logic                    found;
    logic [4:0]              rs_cur;

    function automatic cls_e decode(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd);
        cls_e c;
        case (op)
            7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011: c = CLS_MAIN;
            7'b1101111, 7'b1100111:                         c = CLS_SUB;
            7'b0000011:                                     c = CLS_LOAD;
            7'b1110011:                                     c = (f3 != 3'd0) ? CLS_CSR : CLS_NONE;
            default:                                        c = CLS_NONE;
        endcase
        if (rd == 5'd0) c = CLS_NONE;
        return c;
    endfunction

    function automatic int ready_stage(input cls_e c);
        case (c)
            CLS_LOAD: return LOAD_READY_STAGE;
            CLS_CSR:  return CSR_READY_STAGE;
            default:  return 0;
        endcase
    endfunction

    // Youngest match decides: a not-yet-ready producer stalls rather than falling back to an older one.
    always_comb begin
        stall_raw   = 1'b0;
        lookup_hit  = '0;
        lookup_data = '0;
        found       = 1'b0;
        rs_cur      = 5'd0;
        for (int j = 0; j < NUM_SRC; j++) begin
            rs_cur = bus.id_rs[5*j +: 5];
            found  = 1'b0;
            for (int s = 0; s < DEPTH; s++) begin
                if (!found && rs_cur != 5'd0 && ent_q[s].valid &&
                    ent_q[s].cls != CLS_NONE && ent_q[s].rd == rs_cur) begin
                    found = 1'b1;
                    if (s >= ready_stage(ent_q[s].cls)) begin
                        lookup_hit[j] = 1'b1;
                        case (ent_q[s].cls)
                            CLS_MAIN: lookup_data[XLEN*j +: XLEN] = bus.stage_main_data[XLEN*s +: XLEN];
                            CLS_CSR:  lookup_data[XLEN*j +: XLEN] = bus.stage_csr_data[XLEN*s +: XLEN];
                            default:  lookup_data[XLEN*j +: XLEN] = bus.stage_sub_data[XLEN*s +: XLEN];
                        endcase
                    end else begin
                        stall_raw = 1'b1;
                    end
                end
            end
        end
    end

    assign stall              = bus.id_valid && !bus.flush && stall_raw;
    assign bus.fwd_hit        = rst ? '0 : lookup_hit;
    assign bus.fwd_data       = rst ? '0 : lookup_data;
    assign bus.load_use_stall = !rst && stall;

    always_comb begin
        ent_d = ent_q;
        if (!bus.hold) begin
            for (int i = DEPTH - 1; i >= 1; i--) begin
                ent_d[i] = ent_q[i-1];
            end
            ent_d[0] = '0;
            if (bus.id_valid && !bus.flush && !stall) begin
                ent_d[0].valid = 1'b1;
                ent_d[0].rd    = bus.id_rd;
                ent_d[0].cls   = decode(bus.id_opcode, bus.id_funct3, bus.id_rd);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            ent_q <= ent_d;
        end
    end

endmodule
